timer_counter: RTL and testbench

Memory-mapped programmable timer on the data-side bus, downstream of the CPU's `m_data_*` port via the system bridge. It drives one bit of `HWInt` back into the core. Software loads a preset and enables it; the block counts down and raises an interrupt at zero. It runs either one-shot (interrupt held until software acknowledges) or auto-reload (one-cycle interrupt pulse per period).

---
 rtl/timer_counter_pkg.sv | 32 +++
 rtl/timer_counter_if.sv | 15 +
 rtl/timer_counter.sv | 128 ++++++++++++
 tb/tb_timer_counter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_counter_pkg.sv
// timer_pkg: definitions shared by the timer_counter design and its bench.
//   - state_t      : FSM state encoding (IDLE=0, LOAD=1, CNT=2, INT=3)
//   - OFF_*        : word offsets decoded from addr[3:2]
//   - CTRL_*       : bit positions inside the CTRL register
//   - MODE_*       : MODE field values; is_reload() classifies a MODE value
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  // Only 01 reloads; 00 and both 1x encodings behave as one-shot.
  function automatic logic is_reload(logic [1:0] mode);
    return mode == MODE_RELOAD;
  endfunction

endpackage

// File: rtl/timer_counter_if.sv
// timer_counter_if: data-side bus slice between the system bridge and the timer.
//   addr  : byte address (only bits 3:2 matter to the timer)
//   we    : write strobe, already qualified by the bridge select
//   wdata : full-word write data
//   rdata : combinational read data returned by the timer
// Modports: master (bridge side) drives addr/we/wdata, slave (timer) drives rdata.
interface timer_counter_if;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output addr, output we, output wdata, input rdata);
  modport slave  (input addr, input we, input wdata, output rdata);
endinterface

// File: rtl/timer_counter.sv
// timer_counter: memory-mapped down-counting timer driving one HWInt line.
// Registers (addr[3:2]): 0 CTRL {IM, MODE[1:0], EN}, 1 PRESET (R/W),
// 2 COUNT (read-only), 3 reserved (reads 0, writes dropped).
// Ports:
//   clk   : system clock
//   reset : synchronous, active-low
//   bus   : timer_counter_if.slave -- addr/we/wdata in, combinational rdata out
//   irq   : interrupt request, flag gated by CTRL.IM
module timer_counter
  import timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  timer_counter_if.slave  bus,
  output logic            irq
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       ctrl;
  logic [CNT_W-1:0] preset;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             flag;

  logic             flag_set;
  logic             flag_clr;
  logic             en_clr;
  logic [1:0]       off;
  logic             wr_ctrl;
  logic             wr_preset;
  logic             en;
  logic [1:0]       mode;
  logic             unused_bits;

  assign off       = bus.addr[3:2];
  assign wr_ctrl   = bus.we && (off == OFF_CTRL);
  assign wr_preset = bus.we && (off == OFF_PRESET);
  assign en        = ctrl[CTRL_EN];
  assign mode      = ctrl[CTRL_MODE_HI:CTRL_MODE_LO];

  // Word-aligned full-word access: the byte-lane and upper address bits carry no meaning here.
  assign unused_bits = ^{bus.addr[31:4], bus.addr[1:0]};

  // Next-state and counter datapath
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    flag_set  = 1'b0;
    flag_clr  = 1'b0;
    en_clr    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        count_nxt = preset;
        state_nxt = ST_CNT;
      end
      ST_CNT: begin
        // Disable freezes COUNT where it is so software can inspect it.
        if (!en) begin
          state_nxt = ST_IDLE;
        end else if (count == '0) begin
          state_nxt = ST_INT;
          flag_set  = 1'b1;
        end else begin
          count_nxt = count - ONE;
        end
      end
      ST_INT: begin
        if (is_reload(mode)) begin
          flag_clr  = 1'b1;
          state_nxt = ST_LOAD;
        end else begin
          en_clr    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Register file and FSM state
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= ST_IDLE;
      ctrl   <= '0;
      preset <= '0;
      count  <= '0;
      flag   <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      // A CTRL write on the same edge as the one-shot EN clear keeps the written value.
      if (wr_ctrl) begin
        ctrl <= bus.wdata[3:0];
      end else if (en_clr) begin
        ctrl[CTRL_EN] <= 1'b0;
      end
      if (wr_preset) preset <= bus.wdata[CNT_W-1:0];
      // A fresh terminal count is never lost to an acknowledge landing on the same edge.
      if (flag_set) begin
        flag <= 1'b1;
      end else if (wr_ctrl || flag_clr) begin
        flag <= 1'b0;
      end
    end
  end

  // Read mux
  always_comb begin
    bus.rdata = '0;
    case (off)
      OFF_CTRL:   bus.rdata[3:0]       = ctrl;
      OFF_PRESET: bus.rdata[CNT_W-1:0] = preset;
      OFF_COUNT:  bus.rdata[CNT_W-1:0] = count;
      default:    bus.rdata = '0;
    endcase
  end

  assign irq = flag & ctrl[CTRL_IM];

endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: self-checking bench for timer_counter.
// Table-driven one-shot vectors, hand-written multi-cycle sequences, and a
// randomized run compared against a behavioural model of the timer.
module tb_timer_counter;

  logic clk = 1'b0;
  logic reset;
  logic irq;

  timer_counter_if bus();

  timer_counter #(.CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          we;
    int          off;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    bit          exp_irq;
  } vec_t;

  vec_t tbl[13];

  // Behavioural model state
  localparam int PH_OFF = 0, PH_ARM = 1, PH_RUN = 2, PH_HIT = 3;
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  bit          m_flag;
  int          m_ph;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chkb(string name, logic act, logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Drive bus inputs; returns 1 time unit later with outputs settled.
  task automatic setin(bit w, int off, logic [31:0] d);
    bus.we    = w;
    bus.addr  = {28'd0, 2'(off), 2'b00};
    bus.wdata = d;
    #1;
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
    bus.we = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    setin(0, 0, 0);
    clk1();
    clk1();
    reset = 1'b1;
  endtask

  task automatic model_clear();
    m_ctrl = '0; m_preset = '0; m_count = '0; m_flag = 0; m_ph = PH_OFF;
  endtask

  function automatic logic [31:0] model_read(int off);
    case (off)
      0:       return {28'd0, m_ctrl};
      1:       return m_preset;
      2:       return m_count;
      default: return 32'd0;
    endcase
  endfunction

  // One clock edge of the timer's documented behaviour.
  task automatic model_edge(bit rn, bit w, int off, logic [31:0] d);
    bit en     = m_ctrl[0];
    bit reload = (m_ctrl[2:1] == 2'b01);
    bit hit    = 0;
    bit drop   = 0;
    if (!rn) begin
      model_clear();
      return;
    end
    case (m_ph)
      PH_OFF: if (en) m_ph = PH_ARM;
      PH_ARM: begin m_count = m_preset; m_ph = PH_RUN; end
      PH_RUN: begin
        if (!en) m_ph = PH_OFF;
        else if (m_count == 0) begin m_ph = PH_HIT; hit = 1; end
        else m_count = m_count - 1;
      end
      default: begin
        if (reload) begin m_flag = 0; m_ph = PH_ARM; end
        else begin drop = 1; m_ph = PH_OFF; end
      end
    endcase
    if (drop) m_ctrl[0] = 1'b0;
    if (w && off == 0) begin
      m_ctrl = d[3:0];
      m_flag = 0;
    end
    if (w && off == 1) m_preset = d;
    if (hit) m_flag = 1;
  endtask

  initial begin
    // One-shot vectors: PRESET=3, CTRL=1001 committed at edge k (row 1).
    tbl[0]  = '{1, 1, 32'd3, 32'd0, 0};
    tbl[1]  = '{1, 0, 32'd9, 32'd0, 0};
    tbl[2]  = '{0, 2, 32'd0, 32'd0, 0};
    tbl[3]  = '{0, 2, 32'd0, 32'd0, 0};
    tbl[4]  = '{0, 2, 32'd0, 32'd3, 0};
    tbl[5]  = '{0, 2, 32'd0, 32'd2, 0};
    tbl[6]  = '{0, 2, 32'd0, 32'd1, 0};
    tbl[7]  = '{0, 2, 32'd0, 32'd0, 0};
    tbl[8]  = '{0, 2, 32'd0, 32'd0, 1};
    tbl[9]  = '{0, 0, 32'd0, 32'd8, 1};
    tbl[10] = '{1, 0, 32'd0, 32'd8, 1};
    tbl[11] = '{0, 0, 32'd0, 32'd0, 0};
    tbl[12] = '{0, 1, 32'd0, 32'd3, 0};

    // Reset with a CTRL write held active: the write must not land.
    reset = 1'b0;
    setin(1, 0, 32'hF);
    @(posedge clk); #1;
    setin(1, 0, 32'hF);
    clk1();
    reset = 1'b1;
    for (int o = 0; o < 4; o++) begin
      setin(0, o, 0);
      chk($sformatf("reset_rd%0d", o), bus.rdata, 32'd0);
    end
    chkb("reset_irq", irq, 1'b0);
    clk1();
    setin(0, 0, 0);
    chk("reset_ctrl_after", bus.rdata, 32'd0);

    // Table-driven one-shot
    for (int i = 0; i < 13; i++) begin
      setin(tbl[i].we, tbl[i].off, tbl[i].wd);
      chk($sformatf("vec%0d_rdata", i), bus.rdata, tbl[i].exp_rd);
      chkb($sformatf("vec%0d_irq", i), irq, tbl[i].exp_irq);
      clk1();
    end

    // Auto-reload: PRESET=2 gives a 5-cycle period, first pulse after k+5.
    do_reset();
    setin(1, 1, 2); clk1();
    setin(1, 0, 32'hB); clk1();
    for (int j = 0; j < 22; j++) begin
      setin(0, 2, 0);
      chkb($sformatf("reload_irq_j%0d", j), irq, (j >= 5) && (j % 5 == 0));
      if (j == 2) chk("reload_count_full", bus.rdata, 32'd2);
      if (j == 4) chk("reload_count_zero", bus.rdata, 32'd0);
      clk1();
    end
    setin(0, 0, 0);
    chk("reload_ctrl_kept", bus.rdata, 32'hB);

    // Mid-count PRESET change then disable, then re-enable with the new PRESET.
    do_reset();
    setin(1, 1, 10); clk1();
    setin(1, 0, 9); clk1();
    for (int j = 0; j < 13; j++) begin
      if (j == 6) setin(1, 1, 1);
      else if (j == 8) setin(1, 0, 8);
      else begin
        setin(0, 2, 0);
        chk($sformatf("mid_count_j%0d", j), bus.rdata,
            (j < 2) ? 32'd0 : (j <= 9) ? 32'(12 - j) : 32'd3);
      end
      chkb($sformatf("mid_irq_j%0d", j), irq, 1'b0);
      clk1();
    end
    setin(1, 0, 9); clk1();
    begin
      int exp_c[7] = '{3, 3, 1, 0, 0, 0, 0};
      for (int j = 0; j < 7; j++) begin
        setin(0, 2, 0);
        chk($sformatf("reen_count_j%0d", j), bus.rdata, 32'(exp_c[j]));
        chkb($sformatf("reen_irq_j%0d", j), irq, j >= 4);
        clk1();
      end
    end

    // IM=0 one-shot: no irq; then IM=1 write acknowledges, irq stays low.
    do_reset();
    setin(1, 1, 1); clk1();
    setin(1, 0, 1); clk1();
    for (int j = 0; j < 7; j++) begin
      setin(0, 2, 0);
      chkb($sformatf("mask_irq_j%0d", j), irq, 1'b0);
      clk1();
    end
    setin(0, 0, 0);
    chk("mask_en_cleared", bus.rdata, 32'd0);
    setin(1, 0, 8);
    chkb("mask_irq_wr", irq, 1'b0);
    clk1();
    setin(0, 0, 0);
    chk("mask_ctrl_im", bus.rdata, 32'd8);
    chkb("mask_irq_after", irq, 1'b0);

    // PRESET=0: INT three edges after the enabling write.
    do_reset();
    setin(1, 0, 9); clk1();
    for (int j = 0; j < 5; j++) begin
      setin(0, 2, 0);
      chk($sformatf("p0_count_j%0d", j), bus.rdata, 32'd0);
      chkb($sformatf("p0_irq_j%0d", j), irq, j >= 3);
      clk1();
    end

    // Ignored writes, reserved read, CTRL upper bits read back as 0.
    do_reset();
    setin(1, 1, 5); clk1();
    setin(1, 2, 32'h55); clk1();
    setin(1, 3, 32'h77); clk1();
    setin(1, 0, 32'hFFFF_FFF8); clk1();
    setin(0, 0, 0); chk("ign_ctrl", bus.rdata, 32'd8);
    setin(0, 1, 0); chk("ign_preset", bus.rdata, 32'd5);
    setin(0, 2, 0); chk("ign_count", bus.rdata, 32'd0);
    setin(0, 3, 0); chk("ign_reserved", bus.rdata, 32'd0);

    // Reset mid-count aborts with no interrupt.
    do_reset();
    setin(1, 1, 100); clk1();
    setin(1, 0, 9); clk1();
    repeat (52) clk1();
    setin(0, 2, 0);
    chk("rmid_count50", bus.rdata, 32'd50);
    reset = 1'b0;
    clk1();
    for (int o = 0; o < 4; o++) begin
      setin(0, o, 0);
      chk($sformatf("rmid_rd%0d", o), bus.rdata, 32'd0);
    end
    chkb("rmid_irq", irq, 1'b0);
    reset = 1'b1;
    for (int j = 0; j < 110; j++) begin
      setin(0, 2, 0);
      if (irq !== 1'b0 || bus.rdata !== 32'd0) begin
        chkb($sformatf("rmid_quiet_j%0d", j), irq, 1'b0);
        chk($sformatf("rmid_cnt_j%0d", j), bus.rdata, 32'd0);
      end
      clk1();
    end
    setin(0, 2, 0);
    chk("rmid_count_final", bus.rdata, 32'd0);
    chkb("rmid_irq_final", irq, 1'b0);

    // Randomized run against the behavioural model.
    do_reset();
    model_clear();
    for (int n = 0; n < 600; n++) begin
      bit          w   = ($urandom_range(0, 3) == 0);
      int          off = int'($urandom_range(0, 3));
      logic [31:0] d   = (off == 1) ? 32'($urandom_range(0, 6)) : 32'($urandom);
      bit          rn  = ($urandom_range(0, 199) != 0);
      reset = rn;
      setin(w, off, d);
      chk($sformatf("rand%0d_rdata_off%0d", n, off), bus.rdata, model_read(off));
      chkb($sformatf("rand%0d_irq", n), irq, m_flag & m_ctrl[3]);
      model_edge(rn, w, off, d);
      clk1();
    end
    reset = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
